// File: rtl/square_btn_ctrl.sv
// Button front end for the rotating-square driver: sync, debounce, edge-detect, toggle en/cw.
// Optional build macro LONG_PRESS_EN: holding pause for LONG_CYCLES restores en/cw to reset values.

module sbc_debounce #(
   parameter int DB_CYCLES = 2_000_000
) (
   input  logic clk,
   input  logic rst_n,
   input  logic btn,
   output logic accept,
   output logic pressed
);
   typedef enum logic [1:0] {IDLE, WAIT_PRESS, PRESSED, WAIT_RELEASE} db_state_t;

   localparam logic [23:0] DB_LAST = 24'(DB_CYCLES - 1);

   logic      sync1, s;
   db_state_t state, state_n;
   logic [23:0] cnt;

   always_ff @(posedge clk or negedge rst_n) begin
      if (!rst_n) begin
         sync1 <= 1'b0;
         s     <= 1'b0;
         state <= IDLE;
         cnt   <= '0;
      end else begin
         sync1 <= btn;
         s     <= sync1;
         state <= state_n;
         // counter restarts on every state change and otherwise saturates
         if (state_n != state) cnt <= '0;
         else if (cnt != '1)   cnt <= cnt + 24'd1;
      end
   end

   always_comb begin
      state_n = state;
      accept  = 1'b0;
      case (state)
         IDLE:       if (s) state_n = WAIT_PRESS;
         WAIT_PRESS: begin
            if (!s) state_n = IDLE;
            else if (cnt == DB_LAST) begin
               state_n = PRESSED;
               accept  = 1'b1;
            end
         end
         PRESSED:    if (!s) state_n = WAIT_RELEASE;
         WAIT_RELEASE: begin
            if (s) state_n = PRESSED;
            else if (cnt == DB_LAST) state_n = IDLE;
         end
         default:    state_n = IDLE;
      endcase
   end

   assign pressed = (state == PRESSED);
endmodule

module square_btn_ctrl #(
   parameter int   DB_CYCLES   = 2_000_000,
   parameter logic EN_RST      = 1'b0,
   parameter logic CW_RST      = 1'b1,
   parameter int   LONG_CYCLES = 200_000_000
) (
   input  logic clk,
   input  logic rst_n,
   input  logic btn_pause,
   input  logic btn_dir,
   output logic en,
   output logic cw,
   output logic pause_evt,
   output logic dir_evt
);
   if (DB_CYCLES < 2 || DB_CYCLES > 24'hFF_FFFF) begin : g_db_chk
      $error("DB_CYCLES out of range");
   end
   if (LONG_CYCLES < 2 || LONG_CYCLES > 28'hFFF_FFFF) begin : g_long_chk
      $error("LONG_CYCLES out of range");
   end

   logic pause_acc, pause_pressed;
   logic dir_acc, dir_pressed;
   logic long_fire;

   sbc_debounce #(.DB_CYCLES(DB_CYCLES)) u_db_pause (
      .clk(clk), .rst_n(rst_n), .btn(btn_pause),
      .accept(pause_acc), .pressed(pause_pressed)
   );

   sbc_debounce #(.DB_CYCLES(DB_CYCLES)) u_db_dir (
      .clk(clk), .rst_n(rst_n), .btn(btn_dir),
      .accept(dir_acc), .pressed(dir_pressed)
   );

`ifdef LONG_PRESS_EN
   localparam logic [27:0] LONG_LAST = 28'(LONG_CYCLES - 1);
   logic [27:0] lcnt;

   // saturating, so the restore fires only once per hold
   always_ff @(posedge clk or negedge rst_n) begin
      if (!rst_n)              lcnt <= '0;
      else if (!pause_pressed) lcnt <= '0;
      else if (lcnt != '1)     lcnt <= lcnt + 28'd1;
   end

   assign long_fire = pause_pressed && (lcnt == LONG_LAST);
`else
   assign long_fire = 1'b0;
`endif

   always_ff @(posedge clk or negedge rst_n) begin
      if (!rst_n) begin
         en        <= EN_RST;
         cw        <= CW_RST;
         pause_evt <= 1'b0;
         dir_evt   <= 1'b0;
      end else begin
         pause_evt <= pause_acc | long_fire;
         dir_evt   <= dir_acc | long_fire;
         if (long_fire) begin
            en <= EN_RST;
            cw <= CW_RST;
         end else begin
            if (pause_acc) en <= ~en;
            if (dir_acc)   cw <= ~cw;
         end
      end
   end

   logic unused_dir_pressed;
   assign unused_dir_pressed = dir_pressed;
endmodule

// File: tb/tb_square_btn_ctrl.sv
// Directed bench for square_btn_ctrl with DB_CYCLES=8, LONG_CYCLES=64.
module tb_square_btn_ctrl;
   logic clk = 1'b0;
   logic rst_n = 1'b1;
   logic btn_pause = 1'b0;
   logic btn_dir = 1'b0;
   logic en, cw, pause_evt, dir_evt;

   int checks = 0;
   int errors = 0;

   // pulse counts, first/last pulse cycle, last cycle each output changed
   int p_cnt, p_first, p_last, d_cnt, d_first, d_last, en_chg, cw_chg;

   square_btn_ctrl #(.DB_CYCLES(8), .EN_RST(1'b0), .CW_RST(1'b1), .LONG_CYCLES(64)) dut (
      .clk(clk), .rst_n(rst_n), .btn_pause(btn_pause), .btn_dir(btn_dir),
      .en(en), .cw(cw), .pause_evt(pause_evt), .dir_evt(dir_evt)
   );

   always #5 clk = ~clk;

   task automatic clear_rec();
      p_cnt = 0; p_first = 0; p_last = 0;
      d_cnt = 0; d_first = 0; d_last = 0;
      en_chg = 0; cw_chg = 0;
   endtask

   // k counts posedges since the call; sampling happens on the negedge after edge k
   task automatic run_cycles(input int n);
      logic en_q, cw_q;
      en_q = en; cw_q = cw;
      for (int k = 1; k <= n; k++) begin
         @(negedge clk);
         if (pause_evt === 1'b1) begin p_cnt++; if (p_first == 0) p_first = k; p_last = k; end
         if (dir_evt === 1'b1)   begin d_cnt++; if (d_first == 0) d_first = k; d_last = k; end
         if (en !== en_q) en_chg = k;
         if (cw !== cw_q) cw_chg = k;
         en_q = en; cw_q = cw;
      end
   endtask

   task automatic test_reset();
      rst_n = 1'b0;
      repeat (3) @(negedge clk);
      checks++; if (en !== 1'b0) begin errors++; $display("FAIL reset_en: got %b expected 0", en); end
      checks++; if (cw !== 1'b1) begin errors++; $display("FAIL reset_cw: got %b expected 1", cw); end
      checks++; if ({pause_evt, dir_evt} !== 2'b00) begin errors++; $display("FAIL reset_evt: got %b expected 00", {pause_evt, dir_evt}); end
      rst_n = 1'b1;
      clear_rec();
      run_cycles(50);
      checks++; if (p_cnt + d_cnt != 0) begin errors++; $display("FAIL idle_pulses: got %0d expected 0", p_cnt + d_cnt); end
      checks++; if ({en, cw} !== 2'b01) begin errors++; $display("FAIL idle_en_cw: got %b expected 01", {en, cw}); end
   endtask

   task automatic test_clean_press();
      logic exp_en;
      for (int i = 0; i < 2; i++) begin
         exp_en = (i == 0) ? 1'b1 : 1'b0;
         clear_rec();
         btn_pause = 1'b1;
         run_cycles(20);
         checks++; if (p_cnt != 1) begin errors++; $display("FAIL clean_cnt[%0d]: got %0d expected 1", i, p_cnt); end
         checks++; if (p_first != 11) begin errors++; $display("FAIL clean_lat[%0d]: got %0d expected 11", i, p_first); end
         checks++; if (en_chg != 11) begin errors++; $display("FAIL clean_en_edge[%0d]: got %0d expected 11", i, en_chg); end
         checks++; if (en !== exp_en) begin errors++; $display("FAIL clean_en[%0d]: got %b expected %b", i, en, exp_en); end
         checks++; if (d_cnt != 0) begin errors++; $display("FAIL clean_dir[%0d]: got %0d expected 0", i, d_cnt); end
         clear_rec();
         btn_pause = 1'b0;
         run_cycles(20);
         checks++; if (p_cnt != 0 || en !== exp_en) begin errors++; $display("FAIL clean_release[%0d]: got cnt %0d en %b expected 0 %b", i, p_cnt, en, exp_en); end
      end
   endtask

   task automatic test_bounce();
      clear_rec();
      for (int i = 0; i < 5; i++) begin
         btn_dir = 1'b1; run_cycles(3);
         btn_dir = 1'b0; run_cycles(3);
      end
      checks++; if (d_cnt != 0 || cw !== 1'b1) begin errors++; $display("FAIL bounce_reject: got cnt %0d cw %b expected 0 1", d_cnt, cw); end
      clear_rec();
      btn_dir = 1'b1;
      run_cycles(20);
      checks++; if (d_cnt != 1 || d_first != 11) begin errors++; $display("FAIL bounce_accept: got cnt %0d at %0d expected 1 at 11", d_cnt, d_first); end
      checks++; if (cw !== 1'b0 || cw_chg != 11) begin errors++; $display("FAIL bounce_cw: got %b at %0d expected 0 at 11", cw, cw_chg); end
      btn_dir = 1'b0;
      run_cycles(20);
   endtask

   task automatic test_reset_mid();
      clear_rec();
      btn_pause = 1'b1;
      run_cycles(7);
      checks++; if (p_cnt != 0) begin errors++; $display("FAIL mid_pre: got %0d expected 0", p_cnt); end
      rst_n = 1'b0;
      #1;
      checks++; if ({en, cw, pause_evt} !== 3'b010) begin errors++; $display("FAIL mid_async: got %b expected 010", {en, cw, pause_evt}); end
      run_cycles(3);
      checks++; if (p_cnt != 0 || en !== 1'b0) begin errors++; $display("FAIL mid_hold: got cnt %0d en %b expected 0 0", p_cnt, en); end
      rst_n = 1'b1;
      clear_rec();
      run_cycles(20);
      checks++; if (p_cnt != 1 || p_first != 11) begin errors++; $display("FAIL mid_after: got cnt %0d at %0d expected 1 at 11", p_cnt, p_first); end
      checks++; if (en !== 1'b1) begin errors++; $display("FAIL mid_en: got %b expected 1", en); end
      btn_pause = 1'b0;
      run_cycles(20);
   endtask

   task automatic test_simultaneous();
      rst_n = 1'b0;
      run_cycles(3);
      rst_n = 1'b1;
      run_cycles(5);
      clear_rec();
      btn_pause = 1'b1; btn_dir = 1'b1;
      run_cycles(20);
      checks++; if (p_first != 11 || d_first != 11) begin errors++; $display("FAIL simul_lat: got %0d/%0d expected 11/11", p_first, d_first); end
      checks++; if (p_cnt != 1 || d_cnt != 1) begin errors++; $display("FAIL simul_cnt: got %0d/%0d expected 1/1", p_cnt, d_cnt); end
      checks++; if ({en, cw} !== 2'b10) begin errors++; $display("FAIL simul_en_cw: got %b expected 10", {en, cw}); end
      btn_pause = 1'b0; btn_dir = 1'b0;
      run_cycles(20);
   endtask

   task automatic test_long_press();
      clear_rec();
      btn_pause = 1'b1;
      run_cycles(100);
      checks++; if (p_first != 11 || en_chg != 11) begin errors++; $display("FAIL long_accept: got pulse %0d en edge %0d expected 11 11", p_first, en_chg); end
      checks++; if (en !== 1'b0) begin errors++; $display("FAIL long_en: got %b expected 0", en); end
`ifdef LONG_PRESS_EN
      checks++; if (p_cnt != 2 || p_last != 75) begin errors++; $display("FAIL long_pause_evt: got cnt %0d last %0d expected 2 75", p_cnt, p_last); end
      checks++; if (d_cnt != 1 || d_first != 75) begin errors++; $display("FAIL long_dir_evt: got cnt %0d at %0d expected 1 75", d_cnt, d_first); end
      checks++; if (cw !== 1'b1 || cw_chg != 75) begin errors++; $display("FAIL long_cw: got %b at %0d expected 1 at 75", cw, cw_chg); end
`else
      checks++; if (p_cnt != 1 || d_cnt != 0) begin errors++; $display("FAIL long_pulses: got %0d/%0d expected 1/0", p_cnt, d_cnt); end
      checks++; if (cw !== 1'b0) begin errors++; $display("FAIL long_cw: got %b expected 0", cw); end
`endif
      btn_pause = 1'b0;
      run_cycles(20);
   endtask

   initial begin
      test_reset();
      test_clean_press();
      test_bounce();
      test_reset_mid();
      test_simultaneous();
      test_long_press();
      $display("Simulation finished: %0d checks, %0d errors", checks, errors);
      $finish;
   end
endmodule
